burst_mem_responder: RTL

Memory-side responder for the 64-bit, 4-beat cacheline burst interface driven by the top-level (mem_addr/mem_rdata/mem_wdata/mem_read/mem_write/mem_resp).
- Holds a line-organised backing store.
- Serves each 256-bit line as four 64-bit beats after a programmable access latency.
- Used as the synthesizable memory end of the top-level bus in integration and FPGA builds.

---
 rtl/burst_mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/burst_mem_responder.sv
// Memory end of the 64-bit x 4-beat cacheline burst bus.
// Each request is answered after LATENCY idle cycles with four consecutive
// beats of one 256-bit line. Storage is kept as 64-bit words addressed by
// {line, beat} so that writes can land one beat at a time.
module burst_mem_responder #(
  parameter int LINE_DEG = 10,
  parameter int LATENCY  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  output logic [63:0] mem_rdata,
  input  logic [63:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  output logic        err
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam int WORDS = 2 ** (LINE_DEG + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [LAT_W-1:0]    lat_q;
  logic [1:0]          beat_q;
  logic [LINE_DEG-1:0] line_q;
  logic                op_rd_q;
  logic                resp_q;
  logic                err_q;

  logic [63:0]         mem_q [WORDS];

  logic [LINE_DEG-1:0] line_d;
  logic                req_d;
  logic                unused_addr;

  // Line index taken from the address; offset bits and high bits are dropped.
  assign line_d      = mem_addr[LINE_DEG+4:5];
  assign req_d       = mem_read | mem_write;
  assign unused_addr = ^{mem_addr[31:LINE_DEG+5], mem_addr[4:0]};

  // Burst sequencer: accept, count latency, stream four beats, wait for release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      op_rd_q <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_d) begin
            line_q  <= line_d;
            op_rd_q <= mem_read;
            beat_q  <= '0;
            // Simultaneous read and write is served as a read but flagged.
            if (mem_read && mem_write) err_q <= 1'b1;
            if (LATENCY == 0) begin
              state_q <= S_BURST;
              resp_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              lat_q   <= LAT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!req_d) err_q <= 1'b1;
          if (lat_q == '0) begin
            state_q <= S_BURST;
            resp_q  <= 1'b1;
            beat_q  <= '0;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_BURST: begin
          // A dropped request is an initiator bug; the burst still completes.
          if (!req_d) err_q <= 1'b1;
          if (beat_q == 2'd3) begin
            state_q <= S_DONE;
            resp_q  <= 1'b0;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        S_DONE: begin
          // A held request must be released before the next one is accepted.
          if (!req_d) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Backing store, one 64-bit beat written per responding cycle of a write.
  always_ff @(posedge clk) begin
    if (resp_q && !op_rd_q) mem_q[{line_q, beat_q}] <= mem_wdata;
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = (resp_q && op_rd_q) ? mem_q[{line_q, beat_q}] : 64'd0;
  assign err       = err_q;

endmodule
